db_affine_responder: RTL and testbench
======================================

Name: db_affine_responder

Overview:
- Responder end of the double-buffer memory stream protocol: the initiator pushes words with wen_in/data_in and pulls words with ren_in, and this block answers with data_out/valid_out.
- Holds two ping-pong banks. The write side fills one bank sequentially while the read side drains the other through a 3-D affine address pattern (strides and ranges).
- Used as a cycle-accurate reference responder in the memory-controller verification tops, and as a lightweight standalone double buffer.

Parameters:
DATA_W, 16, data word width
DEPTH_MAX, 64, words per bank (power of 2)
ADDR_W, 6, log2(DEPTH_MAX)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
clk_en  in  1  when 0, all state frozen and outputs held
flush  in  1  synchronous clear of all state (only acts when clk_en=1)
wen_in  in  1  write request
data_in  in  DATA_W  write data
wen_ready  out  1  write bank can accept
ren_in  in  1  read request
ren_ready  out  1  read bank holds a full bank
data_out  out  DATA_W  read data
valid_out  out  1  data_out valid
depth  in  16  writes per bank, 1..DEPTH_MAX
iter_cnt  in  16  reads per bank, >=1
stride_0, stride_1, stride_2  in  16 each  address step per dimension
range_0, range_1, range_2  in  16 each  extent per dimension, >=1
full  out  1  both banks full
empty  out  1  neither bank full

Behaviour:
- Config inputs must be static while out of reset; changing them mid-bank is undefined.
- State: bank_full[1:0], wsel, rsel, wcnt[15:0], rcnt[15:0], indices i0/i1/i2, partial offsets a0/a1/a2.
- Read address = (a0+a1+a2) truncated to ADDR_W. Adders only, no multipliers.
- Reset (reset=0, asynchronous) and flush: bank_full=0, wsel=0, rsel=0, all counters/indices/offsets=0, valid_out=0, data_out=0. flush wins over any same-cycle request.
- Handshake outputs: wen_ready = !bank_full[wsel]; ren_ready = bank_full[rsel]; full = &bank_full; empty = ~|bank_full.
- Write accept (clk_en & wen_in & wen_ready):
  - bank[wsel][wcnt] <= data_in.
  - If wcnt == depth-1: bank_full[wsel] <= 1, wsel toggles, wcnt <= 0. Otherwise wcnt++.
  - wen_in while !wen_ready: ignored, no state change.
- Read accept (clk_en & ren_in & ren_ready):
  - Next cycle: data_out = bank[rsel][addr], valid_out = 1. Latency is exactly 1 cycle.
  - Any cycle with no accepted read: valid_out = 0 and data_out holds its last value.
  - Index advance: if i0 < range_0-1, i0++ and a0 += stride_0. Otherwise i0 = 0, a0 = 0, and dimension 1 advances the same way. Dimension 1 wrap advances dimension 2. Dimension 2 wrap clears i2/a2 (pattern restarts).
  - If rcnt == iter_cnt-1: bank_full[rsel] <= 0, rsel toggles, rcnt and all indices/offsets <= 0. Otherwise rcnt++.
  - ren_in while !ren_ready: ignored, no valid_out.
- Simultaneous write-complete and read-complete in one cycle: both updates apply, each to its own bank flag.
- A write into the bank that is being released this cycle is impossible, because wen_ready is based on registered flags.
- Read of a location not written in the current fill returns stale contents. No X-propagation guarantee.
- The bank array is never cleared by reset or flush; only the flags, counters and pointers are.

Optional Feature:
- Macro DB_AFFINE_ERR_FLAGS_EN. When defined, adds two outputs:
  - wr_ovf: sticky, set on wen_in & !wen_ready & clk_en.
  - rd_unf: sticky, set on ren_in & !ren_ready & clk_en.
  - Both are cleared by reset or flush.
- When undefined, these ports and their logic are absent, and illegal requests are silently ignored.

Test Plan:
- Strides 1/3/9, ranges 3/3/3, depth=27, iter_cnt=27. Write 0..26, then 27 reads -> data_out 0..26 in order, each 1 cycle after ren, valid_out high 27 cycles, then ren_ready=0 and empty=1.
- Transpose: strides 3/1/0, ranges 3/3/1, depth=9, iter_cnt=9. Write 0..8, read -> 0,3,6,1,4,7,2,5,8.
- depth=4, iter_cnt=4. Write 8 words, no reads -> full=1, wen_ready=0. A 9th wen_in is ignored; with DB_AFFINE_ERR_FLAGS_EN, wr_ovf=1.
- Ping-pong overlap: bank0 full; write bank1 while reading bank0, completing both in the same cycle -> bank_full=2'b10, rsel=1, wsel=0, reads continue from bank1 with no gap.
- Reset mid-operation: assert reset=0 during the 3rd read of a bank -> valid_out=0 and empty=1 immediately. After release, a fresh fill/read returns the new data from address 0.
- clk_en=0 for 5 cycles mid-read with ren_in held high -> no valid_out and no counter advance. Resuming gives the next data in sequence.

Source files
------------

// File: rtl/db_affine_responder.sv
`default_nettype none
// ============================================================================
// Module   : db_affine_responder
// Brief    : Ping-pong double buffer. One bank fills sequentially while the
//            other drains through a 3-D affine address walk. The optional
//            macro DB_AFFINE_ERR_FLAGS_EN adds sticky wr_ovf / rd_unf outputs.
// Revision : 1.0 - initial release
// ============================================================================
module db_affine_responder #(
    parameter int DATA_W    = 16,
    parameter int DEPTH_MAX = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              wen_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              wen_ready,
    input  logic              ren_in,
    output logic              ren_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [15:0]       depth,
    input  logic [15:0]       iter_cnt,
    input  logic [15:0]       stride_0,
    input  logic [15:0]       stride_1,
    input  logic [15:0]       stride_2,
    input  logic [15:0]       range_0,
    input  logic [15:0]       range_1,
    input  logic [15:0]       range_2,
    output logic              full,
    output logic              empty
`ifdef DB_AFFINE_ERR_FLAGS_EN
    ,
    output logic              wr_ovf,
    output logic              rd_unf
`endif
);

    logic [DATA_W-1:0] r_mem [0:2*DEPTH_MAX-1];

    logic [1:0]        r_bank_full;
    logic              r_wsel;
    logic              r_rsel;
    logic [15:0]       r_wcnt;
    logic [15:0]       r_rcnt;
    logic [15:0]       r_i0, r_i1, r_i2;
    logic [15:0]       r_a0, r_a1, r_a2;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic              w_wen_acc;
    logic              w_ren_acc;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_i0_more, w_i1_more, w_i2_more;
    logic [15:0]       w_i0_n, w_i1_n, w_i2_n;
    logic [15:0]       w_a0_n, w_a1_n, w_a2_n;
    logic [1:0]        w_full_n;

    assign wen_ready = ~r_bank_full[r_wsel];
    assign ren_ready = r_bank_full[r_rsel];
    assign full      = &r_bank_full;
    assign empty     = ~|r_bank_full;
    assign data_out  = r_data;
    assign valid_out = r_valid;

    assign w_wen_acc = clk_en & ~flush & wen_in & wen_ready;
    assign w_ren_acc = clk_en & ~flush & ren_in & ren_ready;
    assign w_wr_last = (r_wcnt == depth - 16'd1);
    assign w_rd_last = (r_rcnt == iter_cnt - 16'd1);

    // Offsets accumulate modulo 2^16; only the low bits form the bank address.
    assign w_raddr   = r_a0[ADDR_W-1:0] + r_a1[ADDR_W-1:0] + r_a2[ADDR_W-1:0];

    assign w_i0_more = (r_i0 < range_0 - 16'd1);
    assign w_i1_more = (r_i1 < range_1 - 16'd1);
    assign w_i2_more = (r_i2 < range_2 - 16'd1);

    // Odometer-style carry from dimension 0 into 1 and then 2.
    always_comb begin
        w_i0_n = r_i0 + 16'd1;
        w_a0_n = r_a0 + stride_0;
        w_i1_n = r_i1;
        w_a1_n = r_a1;
        w_i2_n = r_i2;
        w_a2_n = r_a2;
        if (!w_i0_more) begin
            w_i0_n = '0;
            w_a0_n = '0;
            if (w_i1_more) begin
                w_i1_n = r_i1 + 16'd1;
                w_a1_n = r_a1 + stride_1;
            end else begin
                w_i1_n = '0;
                w_a1_n = '0;
                if (w_i2_more) begin
                    w_i2_n = r_i2 + 16'd1;
                    w_a2_n = r_a2 + stride_2;
                end else begin
                    w_i2_n = '0;
                    w_a2_n = '0;
                end
            end
        end
    end

    always_comb begin
        w_full_n = r_bank_full;
        if (w_wen_acc && w_wr_last) begin
            w_full_n[r_wsel] = 1'b1;
        end
        if (w_ren_acc && w_rd_last) begin
            w_full_n[r_rsel] = 1'b0;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (w_wen_acc) begin
            r_mem[{r_wsel, r_wcnt[ADDR_W-1:0]}] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank_full <= '0;
            r_wsel      <= 1'b0;
            r_rsel      <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_i0        <= '0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                r_bank_full <= '0;
                r_wsel      <= 1'b0;
                r_rsel      <= 1'b0;
                r_wcnt      <= '0;
                r_rcnt      <= '0;
                r_i0        <= '0;
                r_i1        <= '0;
                r_i2        <= '0;
                r_a0        <= '0;
                r_a1        <= '0;
                r_a2        <= '0;
                r_data      <= '0;
                r_valid     <= 1'b0;
            end else begin
                r_bank_full <= w_full_n;
                r_valid     <= w_ren_acc;
                if (w_ren_acc) begin
                    r_data <= r_mem[{r_rsel, w_raddr}];
                end
                if (w_wen_acc) begin
                    if (w_wr_last) begin
                        r_wsel <= ~r_wsel;
                        r_wcnt <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                if (w_ren_acc) begin
                    if (w_rd_last) begin
                        r_rsel <= ~r_rsel;
                        r_rcnt <= '0;
                        r_i0   <= '0;
                        r_i1   <= '0;
                        r_i2   <= '0;
                        r_a0   <= '0;
                        r_a1   <= '0;
                        r_a2   <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + 16'd1;
                        r_i0   <= w_i0_n;
                        r_i1   <= w_i1_n;
                        r_i2   <= w_i2_n;
                        r_a0   <= w_a0_n;
                        r_a1   <= w_a1_n;
                        r_a2   <= w_a2_n;
                    end
                end
            end
        end
    end

`ifdef DB_AFFINE_ERR_FLAGS_EN
    logic r_wr_ovf;
    logic r_rd_unf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ovf <= 1'b0;
            r_rd_unf <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                r_wr_ovf <= 1'b0;
                r_rd_unf <= 1'b0;
            end else begin
                if (wen_in && !wen_ready) begin
                    r_wr_ovf <= 1'b1;
                end
                if (ren_in && !ren_ready) begin
                    r_rd_unf <= 1'b1;
                end
            end
        end
    end

    assign wr_ovf = r_wr_ovf;
    assign rd_unf = r_rd_unf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_db_affine_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_db_affine_responder
// Brief    : Self-checking bench for db_affine_responder: directed scenarios
//            plus randomized traffic against a bank-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_db_affine_responder;

    localparam int c_dmax = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;
    logic        wen_in = 1'b0;
    logic [15:0] data_in = '0;
    logic        ren_in = 1'b0;
    logic [15:0] depth = 16'd1, iter_cnt = 16'd1;
    logic [15:0] stride_0 = '0, stride_1 = '0, stride_2 = '0;
    logic [15:0] range_0 = 16'd1, range_1 = 16'd1, range_2 = 16'd1;
    logic        wen_ready, ren_ready, valid_out, full, empty;
    logic [15:0] data_out;
`ifdef DB_AFFINE_ERR_FLAGS_EN
    logic        wr_ovf, rd_unf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    db_affine_responder #(.DATA_W(16), .DEPTH_MAX(64), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
        .wen_in(wen_in), .data_in(data_in), .wen_ready(wen_ready),
        .ren_in(ren_in), .ren_ready(ren_ready),
        .data_out(data_out), .valid_out(valid_out),
        .depth(depth), .iter_cnt(iter_cnt),
        .stride_0(stride_0), .stride_1(stride_1), .stride_2(stride_2),
        .range_0(range_0), .range_1(range_1), .range_2(range_2),
        .full(full), .empty(empty)
`ifdef DB_AFFINE_ERR_FLAGS_EN
        , .wr_ovf(wr_ovf), .rd_unf(rd_unf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: bank contents plus counts of filled banks and
    // progress through the current fill / drain.
    logic [15:0] m_mem   [0:1][0:c_dmax-1];
    bit          m_known [0:1][0:c_dmax-1];
    int          m_nfull, m_wsel, m_rsel, m_wcnt, m_rcnt;
    logic        m_valid;
    logic [15:0] m_data;
    bit          m_dknown;
    bit          m_wovf, m_runf;

    function automatic void m_clear();
        m_nfull = 0; m_wsel = 0; m_rsel = 0; m_wcnt = 0; m_rcnt = 0;
        m_valid = 1'b0; m_data = '0; m_dknown = 1'b1;
        m_wovf = 1'b0; m_runf = 1'b0;
    endfunction

    // Address of the k-th read in a bank: decompose k into 3-D indices.
    function automatic int exp_addr(int k);
        int r0, r1, r2, n, i0, i1, i2;
        r0 = int'(range_0); r1 = int'(range_1); r2 = int'(range_2);
        n  = k % (r0 * r1 * r2);
        i0 = n % r0;
        i1 = (n / r0) % r1;
        i2 = n / (r0 * r1);
        return (i0 * int'(stride_0) + i1 * int'(stride_1) + i2 * int'(stride_2)) % c_dmax;
    endfunction

    function automatic void m_step(logic w, logic [15:0] d, logic r, logic ce, logic fl);
        bit wacc, racc;
        int a;
        if (!ce) return;
        if (fl) begin
            m_clear();
            return;
        end
        wacc = w && (m_nfull < 2);
        racc = r && (m_nfull > 0);
        if (w && !wacc) m_wovf = 1'b1;
        if (r && !racc) m_runf = 1'b1;
        m_valid = racc;
        if (racc) begin
            a = exp_addr(m_rcnt);
            m_data   = m_mem[m_rsel][a];
            m_dknown = m_known[m_rsel][a];
        end
        if (wacc) begin
            m_mem[m_wsel][m_wcnt]   = d;
            m_known[m_wsel][m_wcnt] = 1'b1;
            if (m_wcnt == int'(depth) - 1) begin
                m_nfull++; m_wsel ^= 1; m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end
        if (racc) begin
            if (m_rcnt == int'(iter_cnt) - 1) begin
                m_nfull--; m_rsel ^= 1; m_rcnt = 0;
            end else begin
                m_rcnt++;
            end
        end
    endfunction

    task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                       input logic ce, input logic fl);
        wen_in = w; data_in = d; ren_in = r; clk_en = ce; flush = fl;
        @(posedge clk);
        m_step(w, d, r, ce, fl);
        #1;
    endtask

    task automatic apply_reset(input int dp, input int it, input int s0, input int s1,
                               input int s2, input int r0, input int r1, input int r2);
        reset = 1'b0;
        wen_in = 1'b0; ren_in = 1'b0; clk_en = 1'b1; flush = 1'b0;
        depth = 16'(dp); iter_cnt = 16'(it);
        stride_0 = 16'(s0); stride_1 = 16'(s1); stride_2 = 16'(s2);
        range_0 = 16'(r0); range_1 = 16'(r1); range_2 = 16'(r2);
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(4, 4, 1, 0, 0, 4, 1, 1);
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        n_checks++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_out); end
        n_checks++; if (wen_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wen_ready got=%b exp=1", wen_ready); end
        n_checks++; if (ren_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ren_ready got=%b exp=0", ren_ready); end
        n_checks++; if (full !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reset_flags got full=%b empty=%b exp 0/1", full, empty); end
    endtask

    task automatic test_linear();
        apply_reset(27, 27, 1, 3, 9, 3, 3, 3);
        for (int k = 0; k < 27; k++) cyc(1'b1, 16'(k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 27; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(k)) begin
                n_fail++; $display("FAIL linear_read%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, k);
            end
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (valid_out !== 1'b0 || ren_ready !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL linear_done got v=%b rr=%b empty=%b exp 0/0/1", valid_out, ren_ready, empty);
        end
    endtask

    task automatic test_transpose();
        int exp_seq [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        apply_reset(9, 9, 3, 1, 0, 3, 3, 1);
        for (int k = 0; k < 9; k++) cyc(1'b1, 16'(k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(exp_seq[k])) begin
                n_fail++; $display("FAIL transpose_read%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, exp_seq[k]);
            end
        end
    endtask

    task automatic test_full();
        apply_reset(4, 4, 1, 0, 0, 4, 1, 1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'(16'h40 + k), 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (full !== 1'b1 || wen_ready !== 1'b0 || empty !== 1'b0) begin
            n_fail++; $display("FAIL full_after8 got full=%b wr=%b empty=%b exp 1/0/0", full, wen_ready, empty);
        end
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (full !== 1'b1 || wen_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_after9 got full=%b wr=%b exp 1/0", full, wen_ready);
        end
`ifdef DB_AFFINE_ERR_FLAGS_EN
        n_checks++; if (wr_ovf !== 1'b1) begin n_fail++; $display("FAIL full_wr_ovf got=%b exp=1", wr_ovf); end
        n_checks++; if (rd_unf !== 1'b0) begin n_fail++; $display("FAIL full_rd_unf got=%b exp=0", rd_unf); end
`endif
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(16'h40 + k)) begin
                n_fail++; $display("FAIL full_read%0d got v=%b d=%h exp v=1 d=%h", k, valid_out, data_out, 16'(16'h40 + k));
            end
        end
    endtask

    task automatic test_overlap();
        apply_reset(4, 4, 1, 0, 0, 4, 1, 1);
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'(100 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'(200 + k), 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(100 + k)) begin
                n_fail++; $display("FAIL overlap_read%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, 100 + k);
            end
        end
        n_checks++;
        if (full !== 1'b0 || empty !== 1'b0 || wen_ready !== 1'b1 || ren_ready !== 1'b1) begin
            n_fail++; $display("FAIL overlap_flags got full=%b empty=%b wr=%b rr=%b exp 0/0/1/1", full, empty, wen_ready, ren_ready);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(200 + k)) begin
                n_fail++; $display("FAIL overlap_bank1_read%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, 200 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(4, 4, 1, 0, 0, 4, 1, 1);
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'(30 + k), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        ren_in = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_clear();
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || empty !== 1'b1 || data_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid got v=%b empty=%b d=%h exp 0/1/0", valid_out, empty, data_out);
        end
        ren_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'(50 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(50 + k)) begin
                n_fail++; $display("FAIL reset_mid_refill%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, 50 + k);
            end
        end
    endtask

    task automatic test_clk_en();
        apply_reset(8, 8, 1, 0, 0, 8, 1, 1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'(10 + k), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(10 + k)) begin
                n_fail++; $display("FAIL clken_pre%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, 10 + k);
            end
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (valid_out !== 1'b0 || data_out !== 16'd12) begin
                n_fail++; $display("FAIL clken_frozen%0d got v=%b d=%0d exp v=0 d=12", k, valid_out, data_out);
            end
        end
        for (int k = 3; k < 8; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(10 + k)) begin
                n_fail++; $display("FAIL clken_resume%0d got v=%b d=%0d exp v=1 d=%0d", k, valid_out, data_out, 10 + k);
            end
        end
    endtask

    task automatic test_random();
        for (int cfg = 0; cfg < 5; cfg++) begin
            apply_reset(int'($urandom_range(64, 1)), int'($urandom_range(40, 1)),
                        int'($urandom_range(100, 0)), int'($urandom_range(100, 0)),
                        int'($urandom_range(100, 0)), int'($urandom_range(4, 1)),
                        int'($urandom_range(4, 1)), int'($urandom_range(4, 1)));
            for (int c = 0; c < 300; c++) begin
                cyc(logic'($urandom_range(99, 0) < 60), 16'($urandom),
                    logic'($urandom_range(99, 0) < 60),
                    logic'($urandom_range(99, 0) < 90),
                    logic'($urandom_range(199, 0) == 0));
                n_checks++;
                if (wen_ready !== (m_nfull < 2) || ren_ready !== (m_nfull > 0) ||
                    full !== (m_nfull == 2) || empty !== (m_nfull == 0)) begin
                    n_fail++; $display("FAIL rand_flags cfg%0d cyc%0d got wr=%b rr=%b full=%b empty=%b exp nfull=%0d",
                                       cfg, c, wen_ready, ren_ready, full, empty, m_nfull);
                end
                n_checks++;
                if (valid_out !== m_valid) begin
                    n_fail++; $display("FAIL rand_valid cfg%0d cyc%0d got=%b exp=%b", cfg, c, valid_out, m_valid);
                end
                if (m_dknown) begin
                    n_checks++;
                    if (data_out !== m_data) begin
                        n_fail++; $display("FAIL rand_data cfg%0d cyc%0d got=%h exp=%h", cfg, c, data_out, m_data);
                    end
                end
`ifdef DB_AFFINE_ERR_FLAGS_EN
                n_checks++;
                if (wr_ovf !== m_wovf || rd_unf !== m_runf) begin
                    n_fail++; $display("FAIL rand_err cfg%0d cyc%0d got ovf=%b unf=%b exp %b/%b", cfg, c, wr_ovf, rd_unf, m_wovf, m_runf);
                end
`endif
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < c_dmax; a++) begin
                m_known[b][a] = 1'b0;
                m_mem[b][a]   = '0;
            end
        test_reset();
        test_linear();
        test_transpose();
        test_full();
        test_overlap();
        test_reset_mid();
        test_clk_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
